layer_mac_engine: RTL and testbench

Datapath responder to the neural-network sequencer. It accepts a per-layer compute command (hidden layer 1, hidden layer 2 or output), runs the layer's multiply-accumulates serially on one signed multiplier, and applies shift, ReLU and saturation. It then pulses calculation_done back to the sequencer. Hidden-layer results go to an internal ping-pong activation buffer; output-layer results stream out on a result port.

---
 rtl/layer_mac_engine_if.sv | 39 +++
 rtl/layer_mac_engine.sv | 171 +++++++++++++++++
 tb/tb_layer_mac_engine.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_mac_engine_if.sv
`default_nettype none
// ============================================================
// Module   : layer_mac_engine_if
// Brief    : Command, sample, weight and result bus of the MAC engine.
// Revision : 1.0 - initial release
// ============================================================
interface layer_mac_engine_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
);
  logic                     cmd_valid;
  logic [1:0]               cmd_layer;
  logic [IDX_W:0]           cmd_len_in;
  logic [IDX_W:0]           cmd_len_out;
  logic                     x_wr_en;
  logic [IDX_W-1:0]         x_wr_idx;
  logic [DATA_W-1:0]        x_wr_data;
  logic [2+2*IDX_W-1:0]     w_addr;
  logic                     w_ren;
  logic [DATA_W-1:0]        w_rdata;
  logic                     y_valid;
  logic [IDX_W-1:0]         y_idx;
  logic [DATA_W-1:0]        y_data;
  logic                     busy;
  logic                     calculation_done;

  modport master (
    output cmd_valid, cmd_layer, cmd_len_in, cmd_len_out,
    output x_wr_en, x_wr_idx, x_wr_data, w_rdata,
    input  w_addr, w_ren, y_valid, y_idx, y_data, busy, calculation_done
  );

  modport slave (
    input  cmd_valid, cmd_layer, cmd_len_in, cmd_len_out,
    input  x_wr_en, x_wr_idx, x_wr_data, w_rdata,
    output w_addr, w_ren, y_valid, y_idx, y_data, busy, calculation_done
  );
endinterface
`default_nettype wire

// File: rtl/layer_mac_engine.sv
`default_nettype none
// ============================================================
// Module   : layer_mac_engine
// Brief    : Serial signed MAC for one NN layer per command, with
//            shift/ReLU/saturation and ping-pong activation banks.
// Revision : 1.0 - initial release
// ============================================================
module layer_mac_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int IDX_W  = 3,
  parameter int FRAC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  layer_mac_engine_if.slave bus
);

  localparam int NUM = 1 << IDX_W;
  localparam int AW  = 2 + 2 * IDX_W;
  localparam int PW  = 2 * DATA_W;

  localparam logic [IDX_W:0]          c_len_max = (IDX_W + 1)'(NUM);
  localparam logic [IDX_W:0]          c_len_one = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0]        c_idx_one = IDX_W'(1);
  localparam logic signed [ACC_W-1:0] c_pos_max = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] c_neg_min = -ACC_W'(1 << (DATA_W - 1));
  localparam logic [DATA_W-1:0]       c_act_max = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0]       c_act_min = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_ACT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [1:0]               r_layer;
  logic [IDX_W:0]           r_len_in;
  logic [IDX_W:0]           r_len_out;
  logic [ACC_W-1:0]         r_acc;
  logic [IDX_W-1:0]         r_o_idx;
  logic [IDX_W-1:0]         r_i_idx;
  logic [DATA_W-1:0]        r_x_prev;
  logic [DATA_W-1:0]        r_bank_a [NUM];
  logic [DATA_W-1:0]        r_bank_b [NUM];

  logic [IDX_W:0]           w_len_in;
  logic [IDX_W:0]           w_len_out;
  logic                     w_skip;
  logic                     w_last_in;
  logic                     w_last_out;
  logic [DATA_W-1:0]        w_operand;
  logic signed [PW-1:0]     w_prod;
  logic [ACC_W-1:0]         w_prod_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic [DATA_W-1:0]        w_act;
  logic                     w_fetch_ren;
  logic [AW-1:0]            w_fetch_addr;
  logic                     w_y_valid;

  assign w_len_in   = (bus.cmd_len_in  > c_len_max) ? c_len_max : bus.cmd_len_in;
  assign w_len_out  = (bus.cmd_len_out > c_len_max) ? c_len_max : bus.cmd_len_out;
  assign w_skip     = (bus.cmd_layer == 2'd3) || (w_len_in == '0) || (w_len_out == '0);
  assign w_last_in  = ({1'b0, r_i_idx} == (r_len_in  - c_len_one));
  assign w_last_out = ({1'b0, r_o_idx} == (r_len_out - c_len_one));

  // Hidden layer 2 consumes bank B; the other layers consume bank A.
  assign w_operand  = (r_layer == 2'd1) ? r_bank_b[r_i_idx] : r_bank_a[r_i_idx];
  assign w_prod     = $signed(r_x_prev) * $signed(bus.w_rdata);
  assign w_prod_ext = {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};
  assign w_shift    = $signed(r_acc) >>> FRAC;

  always_comb begin
    w_act = w_shift[DATA_W-1:0];
    if (r_layer == 2'd2) begin
      if (w_shift > c_pos_max)      w_act = c_act_max;
      else if (w_shift < c_neg_min) w_act = c_act_min;
    end else begin
      if (w_shift < 0)              w_act = '0;
      else if (w_shift > c_pos_max) w_act = c_act_max;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fetch_ren  = 1'b0;
    w_fetch_addr = '0;
    w_y_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) w_state_next = w_skip ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        w_fetch_ren  = 1'b1;
        w_fetch_addr = {r_layer, r_o_idx, r_i_idx};
        if (w_last_in) w_state_next = S_DRAIN;
      end
      S_DRAIN: w_state_next = S_ACT;
      S_ACT: begin
        w_y_valid    = (r_layer == 2'd2);
        w_state_next = w_last_out ? S_DONE : S_FETCH;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_layer   <= '0;
      r_len_in  <= '0;
      r_len_out <= '0;
      r_acc     <= '0;
      r_o_idx   <= '0;
      r_i_idx   <= '0;
      r_x_prev  <= '0;
      for (int k = 0; k < NUM; k++) begin
        r_bank_a[k] <= '0;
        r_bank_b[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.x_wr_en) r_bank_a[bus.x_wr_idx] <= bus.x_wr_data;
          if (bus.cmd_valid) begin
            r_layer   <= bus.cmd_layer;
            r_len_in  <= w_len_in;
            r_len_out <= w_len_out;
            r_acc     <= '0;
            r_o_idx   <= '0;
            r_i_idx   <= '0;
          end
        end
        S_FETCH: begin
          // Weight read this cycle returns next cycle, so the product lags by one.
          r_x_prev <= w_operand;
          r_i_idx  <= r_i_idx + c_idx_one;
          if (r_i_idx != '0) r_acc <= r_acc + w_prod_ext;
        end
        S_DRAIN: r_acc <= r_acc + w_prod_ext;
        S_ACT: begin
          if (r_layer == 2'd0)      r_bank_b[r_o_idx] <= w_act;
          else if (r_layer == 2'd1) r_bank_a[r_o_idx] <= w_act;
          r_acc   <= '0;
          r_i_idx <= '0;
          r_o_idx <= r_o_idx + c_idx_one;
        end
        default: ;
      endcase
    end
  end

  assign bus.w_ren            = w_fetch_ren;
  assign bus.w_addr           = w_fetch_addr;
  assign bus.y_valid          = w_y_valid;
  assign bus.y_idx            = w_y_valid ? r_o_idx : '0;
  assign bus.y_data           = w_y_valid ? w_act : '0;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.calculation_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_layer_mac_engine.sv
`default_nettype none
// ============================================================
// Module   : tb_layer_mac_engine
// Brief    : Self-checking bench for layer_mac_engine against a layer-level model.
// Revision : 1.0 - initial release
// ============================================================
module tb_layer_mac_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer_mac_engine_if #(.DATA_W(8), .IDX_W(3)) bus ();

  layer_mac_engine #(.DATA_W(8), .ACC_W(24), .IDX_W(3), .FRAC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] wmem [256];
  always @(posedge clk) if (bus.w_ren) bus.w_rdata <= wmem[bus.w_addr];

  int n_chk = 0;
  int n_err = 0;
  int mA [8];
  int mB [8];
  int exp_yi [$];
  int exp_yd [$];
  int got_yi [$];
  int got_yd [$];
  int wq [$];
  int busy_cnt;
  int done_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  function automatic int waddr(input int layer, input int o, input int i);
    return (layer << 6) | (o << 3) | i;
  endfunction

  function automatic int wval(input int layer, input int o, input int i);
    return int'($signed(wmem[waddr(layer, o, i)]));
  endfunction

  function automatic void set_w(input int layer, input int o, input int i, input int v);
    wmem[waddr(layer, o, i)] = 8'(v);
  endfunction

  function automatic int count_nz();
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      if (dut.r_bank_a[i] != 8'd0) n++;
      if (dut.r_bank_b[i] != 8'd0) n++;
    end
    return n;
  endfunction

  // Layer-level reference: dot product, floor shift, then clamp/ReLU.
  function automatic void model_run(input int layer, input int lin, input int lout);
    int li, lo, acc, v;
    li = clamp8(lin);
    lo = clamp8(lout);
    if (layer == 3 || li == 0 || lo == 0) return;
    for (int o = 0; o < lo; o++) begin
      acc = 0;
      for (int i = 0; i < li; i++)
        acc += ((layer == 1) ? mB[i] : mA[i]) * wval(layer, o, i);
      v = acc >>> 4;
      if (layer == 2) begin
        v = (v > 127) ? 127 : ((v < -128) ? -128 : v);
        exp_yi.push_back(o);
        exp_yd.push_back(v);
      end else begin
        v = (v < 0) ? 0 : ((v > 127) ? 127 : v);
        if (layer == 0) mB[o] = v;
        else            mA[o] = v;
      end
    end
  endfunction

  task automatic write_x(input int idx, input int val);
    bus.x_wr_en   = 1'b1;
    bus.x_wr_idx  = 3'(idx);
    bus.x_wr_data = 8'(val);
    @(negedge clk);
    bus.x_wr_en   = 1'b0;
    mA[idx] = val;
  endtask

  task automatic run_cmd(input int layer, input int lin, input int lout, input bit poke,
                         input bit do_wr, input int wr_idx, input int wr_data,
                         output int done_cyc);
    done_cyc = -1;
    wq.delete(); got_yi.delete(); got_yd.delete();
    busy_cnt = 0;
    done_cnt = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_layer   = 2'(layer);
    bus.cmd_len_in  = 4'(lin);
    bus.cmd_len_out = 4'(lout);
    if (do_wr) begin
      bus.x_wr_en   = 1'b1;
      bus.x_wr_idx  = 3'(wr_idx);
      bus.x_wr_data = 8'(wr_data);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.x_wr_en   = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (bus.w_ren)   wq.push_back(int'(bus.w_addr));
      if (bus.y_valid) begin
        got_yi.push_back(int'(bus.y_idx));
        got_yd.push_back(int'($signed(bus.y_data)));
      end
      if (bus.busy) busy_cnt++;
      if (bus.calculation_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc >= 0 && k > done_cyc) break;
      if (poke && k == 2) begin
        bus.cmd_valid   = 1'b1;
        bus.cmd_layer   = 2'd2;
        bus.cmd_len_in  = 4'd8;
        bus.cmd_len_out = 4'd8;
        bus.x_wr_en     = 1'b1;
        bus.x_wr_idx    = 3'd0;
        bus.x_wr_data   = 8'd99;
      end else if (poke && k == 3) begin
        bus.cmd_valid = 1'b0;
        bus.x_wr_en   = 1'b0;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.x_wr_en   = 1'b0;
  endtask

  task automatic check_layer(input string tag, input int layer, input int lin, input int lout,
                             input int done_cyc);
    int li, lo, n_exp, exp_done, bad, ea, gi, gd;
    li = clamp8(lin);
    lo = clamp8(lout);
    if (layer == 3 || li == 0 || lo == 0) begin
      n_exp = 0;
      exp_done = 1;
    end else begin
      n_exp = li * lo;
      exp_done = lo * (li + 2) + 1;
    end
    check_eq({tag, "_done_cyc"}, done_cyc, exp_done);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_busy_cyc"}, busy_cnt, exp_done);
    check_eq({tag, "_nreads"}, wq.size(), n_exp);
    bad = -1;
    for (int k = 0; k < wq.size() && k < n_exp; k++) begin
      ea = waddr(layer, k / li, k % li);
      if (wq[k] != ea && bad < 0) bad = k;
    end
    check_eq({tag, "_waddr_seq_bad_at"}, bad, -1);
    check_eq({tag, "_ny"}, got_yd.size(), exp_yd.size());
    for (int k = 0; k < exp_yd.size(); k++) begin
      gi = (k < got_yi.size()) ? got_yi[k] : -999;
      gd = (k < got_yd.size()) ? got_yd[k] : -999;
      check_eq($sformatf("%s_yidx%0d", tag, k), gi, exp_yi[k]);
      check_eq($sformatf("%s_ydata%0d", tag, k), gd, exp_yd[k]);
    end
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s_bankA%0d", tag, i), int'($signed(dut.r_bank_a[i])), mA[i]);
      check_eq($sformatf("%s_bankB%0d", tag, i), int'($signed(dut.r_bank_b[i])), mB[i]);
    end
  endtask

  task automatic do_layer(input string tag, input int layer, input int lin, input int lout,
                          input bit poke, input bit do_wr, input int wr_idx, input int wr_data);
    int dc;
    exp_yi.delete();
    exp_yd.delete();
    if (do_wr) mA[wr_idx] = wr_data;
    model_run(layer, lin, lout);
    run_cmd(layer, lin, lout, poke, do_wr, wr_idx, wr_data, dc);
    check_layer(tag, layer, lin, lout, dc);
  endtask

  initial begin
    int lens [6];
    int cnt;
    bus.cmd_valid = 1'b0; bus.cmd_layer = 2'd0;
    bus.cmd_len_in = 4'd0; bus.cmd_len_out = 4'd0;
    bus.x_wr_en = 1'b0; bus.x_wr_idx = 3'd0; bus.x_wr_data = 8'd0;
    for (int a = 0; a < 256; a++) wmem[a] = 8'd0;
    for (int i = 0; i < 8; i++) begin mA[i] = 0; mB[i] = 0; end

    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.calculation_done), 0);
    check_eq("rst_wren", int'(bus.w_ren), 0);
    check_eq("rst_waddr", int'(bus.w_addr), 0);
    check_eq("rst_yvalid", int'(bus.y_valid), 0);
    check_eq("rst_banks_nonzero", count_nz(), 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic MAC
    write_x(0, 16); write_x(1, 32);
    set_w(0, 0, 0, 16); set_w(0, 0, 1, 16);
    do_layer("mac", 0, 2, 1, 1'b0, 1'b0, 0, 0);
    check_eq("mac_b0", int'($signed(dut.r_bank_b[0])), 48);

    // ReLU on hidden, signed pass-through on output
    set_w(0, 0, 0, -16); set_w(0, 0, 1, -16);
    do_layer("relu", 0, 2, 1, 1'b0, 1'b0, 0, 0);
    check_eq("relu_b0", int'($signed(dut.r_bank_b[0])), 0);
    set_w(2, 0, 0, -16); set_w(2, 0, 1, -16);
    do_layer("outneg", 2, 2, 1, 1'b0, 1'b0, 0, 0);
    check_eq("outneg_y", (got_yd.size() > 0) ? got_yd[0] : 999, -48);

    // Saturation
    write_x(0, 127); write_x(1, 127);
    set_w(0, 0, 0, 127); set_w(0, 0, 1, 127);
    do_layer("satpos", 0, 2, 1, 1'b0, 1'b0, 0, 0);
    check_eq("satpos_b0", int'($signed(dut.r_bank_b[0])), 127);
    set_w(2, 0, 0, -128); set_w(2, 0, 1, -128);
    do_layer("satneg", 2, 2, 1, 1'b0, 1'b0, 0, 0);
    check_eq("satneg_y", (got_yd.size() > 0) ? got_yd[0] : 999, -128);

    // Command hygiene
    set_w(0, 0, 0, 1); set_w(0, 0, 1, 1);
    do_layer("busy_poke", 0, 2, 1, 1'b1, 1'b0, 0, 0);
    do_layer("wr_with_cmd", 0, 2, 1, 1'b0, 1'b1, 1, -64);
    do_layer("noop", 3, 2, 2, 1'b0, 1'b0, 0, 0);
    do_layer("len_out0", 0, 2, 0, 1'b0, 1'b0, 0, 0);
    do_layer("len_in0", 1, 0, 3, 1'b0, 1'b0, 0, 0);

    // Random chained networks; first one is the 4-4-2 shape
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 8; i++) write_x(i, int'($urandom_range(0, 255)) - 128);
      for (int a = 0; a < 256; a++) wmem[a] = 8'($urandom);
      if (it == 0) begin
        lens[0] = 4; lens[1] = 4; lens[2] = 4; lens[3] = 4; lens[4] = 4; lens[5] = 2;
      end else begin
        for (int j = 0; j < 6; j++) lens[j] = int'($urandom_range(1, 10));
      end
      do_layer($sformatf("net%0d_l0", it), 0, lens[0], lens[1], 1'b0, 1'b0, 0, 0);
      do_layer($sformatf("net%0d_l1", it), 1, lens[2], lens[3], 1'b0, 1'b0, 0, 0);
      do_layer($sformatf("net%0d_l2", it), 2, lens[4], lens[5], 1'b0, 1'b0, 0, 0);
    end

    // Reset during FETCH of neuron 2
    write_x(0, 5); write_x(1, 6); write_x(2, 7);
    bus.cmd_valid = 1'b1; bus.cmd_layer = 2'd0;
    bus.cmd_len_in = 4'd3; bus.cmd_len_out = 4'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (11) @(negedge clk);
    check_eq("mid_waddr", int'(bus.w_addr), waddr(0, 2, 1));
    rst = 1'b0;
    #1;
    check_eq("mid_busy", int'(bus.busy), 0);
    check_eq("mid_wren", int'(bus.w_ren), 0);
    check_eq("mid_waddr_rst", int'(bus.w_addr), 0);
    check_eq("mid_yvalid", int'(bus.y_valid), 0);
    check_eq("mid_banks_nonzero", count_nz(), 0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.calculation_done) cnt++;
    end
    check_eq("mid_no_done", cnt, 0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin mA[i] = 0; mB[i] = 0; end
    @(negedge clk);
    write_x(0, 20); write_x(1, -8); write_x(2, 3);
    do_layer("post_rst", 0, 3, 2, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
